safe_map_ctrl: RTL and testbench
================================

Name: safe_map_ctrl

Overview:
Owns the 80x60 safe-zone block map RAM and sequences each level build: clear map, start the safe-zone generator, accept its block writes, then publish the map. Shares the single-port RAM between three users: generator writes, the renderer's fixed-latency read stream and the player-collision request/ack lookup. Sits between game-state logic, the safe-zone generator, the VGA renderer and the collision checker.

Parameters:
SCREEN_WIDTH, 800, screen width in pixels
SCREEN_HEIGHT, 600, screen height in pixels
BLOCK_SIZE, 10, block edge in pixels; MAP_W = 80, MAP_H = 60, DEPTH = 4800 are derived from these
GEN_TIMEOUT, 65535, maximum cycles spent in GEN before aborting

Ports:
clk  in  1  clock
arst_n  in  1  reset, synchronous, active-low
i_regen_req  in  1  request a new level, sampled each cycle
o_gen_start  out  1  one-cycle pulse that starts the generator
i_gen_rdy  in  1  generator idle/done level
i_wr_valid  in  1  generator block write strobe
i_wr_x  in  7  write block column
i_wr_y  in  6  write block row
i_wr_data  in  1  1 = safe
i_rd_en  in  1  renderer read strobe (active video)
i_rd_x  in  7  renderer block column
i_rd_y  in  6  renderer block row
o_rd_valid  out  1  renderer data valid
o_rd_safe  out  1  renderer data
i_col_req  in  1  collision lookup request
i_col_x  in  7  collision block column
i_col_y  in  6  collision block row
o_col_ack  out  1  one-cycle completion pulse
o_col_safe  out  1  lookup result, valid while o_col_ack = 1
o_map_valid  out  1  map is published (state READY)
o_busy  out  1  state is CLEAR or GEN
o_gen_err  out  1  sticky flag: last build timed out

Behaviour:
- Reset: state IDLE; all outputs 0; pending request cleared; RAM contents undefined.
- Address = y*80 + x (13 bits). Coordinates with x >= 80 or y >= 60 are out of range: writes are dropped and reads return 0.
- States:
  - IDLE. i_regen_req -> CLEAR.
  - CLEAR. Write 0 to addresses 0..4799, one per cycle (4800 cycles). On the final address, move to GEN and pulse o_gen_start in the first GEN cycle.
  - GEN. Accept every i_wr_valid; there is no backpressure. Set a flag the first cycle i_gen_rdy = 0. The first cycle with the flag set and i_gen_rdy = 1 -> READY and clear o_gen_err. If GEN_TIMEOUT cycles elapse -> READY and set o_gen_err.
  - READY. o_map_valid = 1. i_regen_req -> CLEAR.
- In CLEAR or GEN, i_regen_req latches one pending request. The pending request is taken on the cycle READY is entered, so READY lasts one cycle before CLEAR. i_wr_valid outside GEN is ignored.
- RAM port priority per cycle:
  1. clear/generator write
  2. render read
  3. collision read
- Render path:
  - Latency is exactly 2 cycles. o_rd_valid(t+2) = i_rd_en(t).
  - o_rd_safe(t+2) = RAM data, or 0 if not READY at time t.
  - Never stalls.
- Collision path:
  - Granted on a cycle with state READY, i_col_req = 1, no lookup in flight and i_rd_en = 0.
  - Coordinates are captured at grant. o_col_ack pulses 2 cycles after grant, with o_col_safe.
  - Requester holds i_col_req and coordinates until the ack. A request still high in the ack cycle is a new request, eligible at the earliest one cycle after the ack.
  - A request pending outside READY waits; it is not dropped.
- o_col_safe is 0 whenever o_col_ack = 0. o_gen_start is exactly one pulse per build.
- The regen request and a generator write in the same cycle are both honoured; the write completes if in GEN.
- Reset mid-build returns to IDLE immediately. Any in-flight collision lookup is discarded without an ack.

Decomposition:
- Package safe_map_pkg:
  - MAP_W, MAP_H, MAP_DEPTH, ADDR_W = 13, X_W = 7, Y_W = 6
  - state enum {IDLE, CLEAR, GEN, READY}
  - function map_addr(x, y) returning an address plus an in-range bit
- Sub-module safe_map_ram: single-port synchronous 4800x1, registered read (1-cycle), write-enable. The controller adds one output register to give 2-cycle latency.

Test Plan:
- Reset, then i_regen_req for one cycle -> o_busy = 1 for the CLEAR phase; o_gen_start pulses exactly at cycle 4801 after the request; o_map_valid = 0.
- Model generator: rdy low 3 cycles after start, writes (5,7)=1 and (79,59)=1, rdy high -> o_map_valid = 1. Render reads of (5,7) and (79,59) return 1, (0,0) returns 0, each 2 cycles after i_rd_en.
- Continuous i_rd_en for 20 cycles with i_col_req held -> no o_col_ack until i_rd_en drops; ack arrives 2 cycles after the first idle cycle with the correct value. Render stream is unbroken.
- Out-of-range read (80,0) and write (0,60) -> read returns 0; no RAM address is corrupted (full readback compare).
- i_regen_req during GEN -> build finishes, READY for 1 cycle, then CLEAR restarts with map cleared (readback all 0 after the next build with no writes).
- Generator never raises rdy, with GEN_TIMEOUT = 100 -> READY after 100 GEN cycles and o_gen_err = 1. Reset mid-CLEAR -> IDLE with all outputs 0 the next cycle.

Source files
------------

// File: rtl/safe_map_pkg.sv
// Shared constants, FSM states and block addressing for the safe-zone map.
// One map bit per 10x10 pixel block, 80x60 blocks.
package safe_map_pkg;

  localparam int MAP_W     = 80;
  localparam int MAP_H     = 60;
  localparam int MAP_DEPTH = MAP_W * MAP_H;
  localparam int ADDR_W    = 13;
  localparam int X_W       = 7;
  localparam int Y_W       = 6;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    GEN,
    READY
  } state_t;

  typedef struct packed {
    logic              ok;
    logic [ADDR_W-1:0] addr;
  } maddr_t;

  function automatic maddr_t map_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    maddr_t r;
    r.ok = (x < X_W'(MAP_W)) &&
           (y < Y_W'(MAP_H));
    r.addr = '0;
    if (r.ok)
      r.addr = ADDR_W'(y) * ADDR_W'(MAP_W)
             + ADDR_W'(x);
    return r;
  endfunction

endpackage

// File: rtl/safe_map_ram.sv
// Single-port 4800x1 block map, registered read, no reset on contents.
// Read-during-write returns the old bit; callers never rely on it.
module safe_map_ram
  import safe_map_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wdata,
  output logic              rdata
);

  logic mem [0:MAP_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/safe_map_ctrl.sv
// Level-build sequencer and RAM arbiter for the safe-zone block map.
// Port order: clear/gen write, then render read, then collision read.
module safe_map_ctrl
  import safe_map_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BLOCK_SIZE    = 10,
  parameter int GEN_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_regen_req,
  output logic       o_gen_start,
  input  logic       i_gen_rdy,
  input  logic       i_wr_valid,
  input  logic [6:0] i_wr_x,
  input  logic [5:0] i_wr_y,
  input  logic       i_wr_data,
  input  logic       i_rd_en,
  input  logic [6:0] i_rd_x,
  input  logic [5:0] i_rd_y,
  output logic       o_rd_valid,
  output logic       o_rd_safe,
  input  logic       i_col_req,
  input  logic [6:0] i_col_x,
  input  logic [5:0] i_col_y,
  output logic       o_col_ack,
  output logic       o_col_safe,
  output logic       o_map_valid,
  output logic       o_busy,
  output logic       o_gen_err
);

  localparam int DEPTH =
    (SCREEN_WIDTH / BLOCK_SIZE) *
    (SCREEN_HEIGHT / BLOCK_SIZE);
  localparam logic [ADDR_W-1:0] CLR_LAST =
    ADDR_W'(DEPTH - 1);
  localparam int TO_W = 17;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(GEN_TIMEOUT - 1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] clr_q;
  logic [TO_W-1:0]   cnt_q;
  logic              seen_q;
  logic              pend_q;
  logic              start_q;
  logic              err_q;
  logic              gen_done;
  logic              gen_to;

  maddr_t w_a, r_a, c_a;

  logic              in_clr, in_gen, in_rdy;
  logic              gen_we;
  logic              ram_we;
  logic              ram_wd;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_q;
  logic              col_grant;

  logic              rd_v1, rd_ok1;
  logic              col_v1, col_ok1;

  assign in_clr = (state_q == CLEAR);
  assign in_gen = (state_q == GEN);
  assign in_rdy = (state_q == READY);

  assign gen_done = seen_q & i_gen_rdy;
  assign gen_to   = (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!arst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (i_regen_req)
          state_d = CLEAR;
      CLEAR:
        if (clr_q == CLR_LAST)
          state_d = GEN;
      GEN:
        if (gen_done || gen_to)
          state_d = READY;
      READY:
        if (i_regen_req || pend_q)
          state_d = CLEAR;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      clr_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= in_clr && (state_d == GEN);
      clr_q   <= in_clr ? clr_q + 1'b1 : '0;
      cnt_q   <= in_gen ? cnt_q + 1'b1 : '0;
      seen_q  <= in_gen & (seen_q | ~i_gen_rdy);
      // READY always leaves after one cycle when a request was queued
      if (in_rdy)
        pend_q <= 1'b0;
      else if ((in_clr || in_gen) && i_regen_req)
        pend_q <= 1'b1;
      if (in_gen && state_d == READY)
        err_q <= ~gen_done;
    end
  end

  always_comb begin
    w_a = map_addr(i_wr_x, i_wr_y);
    r_a = map_addr(i_rd_x, i_rd_y);
    c_a = map_addr(i_col_x, i_col_y);
  end

  assign gen_we = in_gen & i_wr_valid & w_a.ok;
  assign ram_we = in_clr | gen_we;
  assign ram_wd = gen_we & i_wr_data;

  // No writes happen in READY, so a grant never loses the port
  assign col_grant = in_rdy & i_col_req &
                     ~col_v1 & ~o_col_ack &
                     ~i_rd_en;

  always_comb begin
    ram_addr = c_a.addr;
    if (in_clr)
      ram_addr = clr_q;
    else if (gen_we)
      ram_addr = w_a.addr;
    else if (i_rd_en)
      ram_addr = r_a.addr;
  end

  safe_map_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rd_v1      <= 1'b0;
      rd_ok1     <= 1'b0;
      col_v1     <= 1'b0;
      col_ok1    <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_safe  <= 1'b0;
      o_col_ack  <= 1'b0;
      o_col_safe <= 1'b0;
    end else begin
      rd_v1      <= i_rd_en;
      rd_ok1     <= in_rdy & r_a.ok;
      col_v1     <= col_grant;
      col_ok1    <= c_a.ok;
      o_rd_valid <= rd_v1;
      o_rd_safe  <= rd_v1 & rd_ok1 & ram_q;
      o_col_ack  <= col_v1;
      o_col_safe <= col_v1 & col_ok1 & ram_q;
    end
  end

  assign o_gen_start = start_q;
  assign o_map_valid = in_rdy;
  assign o_busy      = in_clr | in_gen;
  assign o_gen_err   = err_q;

endmodule

// File: tb/tb_safe_map_ctrl.sv
// Directed bench for safe_map_ctrl: build sequencing, render stream,
// collision arbitration, range handling, timeout and reset.
module tb_safe_map_ctrl;
  import safe_map_pkg::*;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       i_regen_req;
  logic       o_gen_start;
  logic       i_gen_rdy;
  logic       i_wr_valid;
  logic [6:0] i_wr_x;
  logic [5:0] i_wr_y;
  logic       i_wr_data;
  logic       i_rd_en;
  logic [6:0] i_rd_x;
  logic [5:0] i_rd_y;
  logic       o_rd_valid;
  logic       o_rd_safe;
  logic       i_col_req;
  logic [6:0] i_col_x;
  logic [5:0] i_col_y;
  logic       o_col_ack;
  logic       o_col_safe;
  logic       o_map_valid;
  logic       o_busy;
  logic       o_gen_err;

  always #5 clk = ~clk;

  safe_map_ctrl #(.GEN_TIMEOUT(100)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_regen_req (i_regen_req),
    .o_gen_start (o_gen_start),
    .i_gen_rdy   (i_gen_rdy),
    .i_wr_valid  (i_wr_valid),
    .i_wr_x      (i_wr_x),
    .i_wr_y      (i_wr_y),
    .i_wr_data   (i_wr_data),
    .i_rd_en     (i_rd_en),
    .i_rd_x      (i_rd_x),
    .i_rd_y      (i_rd_y),
    .o_rd_valid  (o_rd_valid),
    .o_rd_safe   (o_rd_safe),
    .i_col_req   (i_col_req),
    .i_col_x     (i_col_x),
    .i_col_y     (i_col_y),
    .o_col_ack   (o_col_ack),
    .o_col_safe  (o_col_safe),
    .o_map_valid (o_map_valid),
    .o_busy      (o_busy),
    .o_gen_err   (o_gen_err)
  );

  typedef struct {
    logic [6:0] x;
    logic [5:0] y;
    logic       exp;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  bit   model [0:4799];
  vec_t vt [10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({o_gen_start, o_rd_valid, o_rd_safe, o_col_ack,
                 o_col_safe, o_map_valid, o_busy, o_gen_err});
  endfunction

  task automatic regen();
    i_regen_req = 1'b1;
    step();
    i_regen_req = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_gen_start && n < 6000);
    chk("gen_start_seen", int'(o_gen_start), 1);
  endtask

  task automatic wr(input int x, input int y, input bit d);
    i_wr_valid = 1'b1;
    i_wr_x = 7'(x);
    i_wr_y = 6'(y);
    i_wr_data = d;
  endtask

  task automatic rd1(input logic [6:0] x, input logic [5:0] y,
                     input logic exp);
    i_rd_en = 1'b1;
    i_rd_x = x;
    i_rd_y = y;
    step();
    i_rd_en = 1'b0;
    chk("rd_not_early", int'(o_rd_valid), 0);
    step();
    chk("rd_valid", int'(o_rd_valid), 1);
    chk($sformatf("rd_safe_%0d_%0d", x, y), int'(o_rd_safe), int'(exp));
  endtask

  task automatic readback(input string nm);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i <= 4800; i++) begin
      if (i < 4800) begin
        i_rd_en = 1'b1;
        i_rd_x = 7'(i % 80);
        i_rd_y = 6'(i / 80);
      end else begin
        i_rd_en = 1'b0;
      end
      step();
      if (i > 0 && (!o_rd_valid || o_rd_safe != model[i-1])) begin
        bad++;
        if (first < 0) first = i - 1;
      end
    end
    step();
    chk($sformatf("%s_bad_first_addr%0d", nm, first), bad, 0);
  endtask

  initial begin
    int n;
    int cbad;
    int rbad;
    logic [6:0] ack_m;
    logic [6:0] safe_m;

    vt[0] = '{7'd5,  6'd7,  1'b1};
    vt[1] = '{7'd79, 6'd59, 1'b1};
    vt[2] = '{7'd0,  6'd0,  1'b0};
    vt[3] = '{7'd80, 6'd0,  1'b0};
    vt[4] = '{7'd0,  6'd60, 1'b0};
    vt[5] = '{7'd4,  6'd7,  1'b0};
    vt[6] = '{7'd6,  6'd7,  1'b0};
    vt[7] = '{7'd79, 6'd58, 1'b0};
    vt[8] = '{7'd1,  6'd1,  1'b0};
    vt[9] = '{7'd127, 6'd63, 1'b0};

    arst_n = 1'b0;
    i_regen_req = 1'b0;
    i_gen_rdy = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_x = '0;
    i_wr_y = '0;
    i_wr_data = 1'b0;
    i_rd_en = 1'b0;
    i_rd_x = '0;
    i_rd_y = '0;
    i_col_req = 1'b0;
    i_col_x = '0;
    i_col_y = '0;
    for (int i = 0; i < 4800; i++) model[i] = 1'b0;

    repeat (3) step();
    chk("reset_outputs", outs(), 0);
    arst_n = 1'b1;
    step();

    // build 1: two safe blocks, one out-of-range write
    regen();
    chk("clear_busy", int'(o_busy), 1);
    chk("clear_map_valid", int'(o_map_valid), 0);
    wait_start(n);
    chk("gen_start_cycle", n + 1, 4801);
    chk("gen_map_valid", int'(o_map_valid), 0);
    i_gen_rdy = 1'b0;
    wr(5, 7, 1'b1);
    step();
    chk("gen_start_width", int'(o_gen_start), 0);
    wr(79, 59, 1'b1);
    step();
    wr(0, 60, 1'b1);
    step();
    i_wr_valid = 1'b0;
    i_gen_rdy = 1'b1;
    step();
    chk("ready_map_valid", int'(o_map_valid), 1);
    chk("ready_busy", int'(o_busy), 0);
    chk("ready_err", int'(o_gen_err), 0);
    model[7*80+5] = 1'b1;
    model[59*80+79] = 1'b1;

    // write outside GEN must be ignored
    wr(1, 1, 1'b1);
    step();
    i_wr_valid = 1'b0;

    for (int i = 0; i < 10; i++) rd1(vt[i].x, vt[i].y, vt[i].exp);
    readback("readback1");

    // collision held off by a continuous render stream
    i_col_req = 1'b1;
    i_col_x = 7'd5;
    i_col_y = 6'd7;
    cbad = 0;
    rbad = 0;
    for (int i = 0; i < 20; i++) begin
      i_rd_en = 1'b1;
      i_rd_x = 7'd79;
      i_rd_y = 6'd59;
      step();
      if (o_col_ack) cbad++;
      if (i > 0 && !(o_rd_valid && o_rd_safe)) rbad++;
    end
    i_rd_en = 1'b0;
    step();
    if (o_col_ack) cbad++;
    if (!(o_rd_valid && o_rd_safe)) rbad++;
    chk("col_ack_blocked", cbad, 0);
    chk("render_unbroken", rbad, 0);
    step();
    chk("col_ack", int'(o_col_ack), 1);
    chk("col_safe", int'(o_col_safe), 1);
    chk("render_drained", int'(o_rd_valid), 0);
    i_col_req = 1'b0;
    step();
    chk("col_ack_single", int'(o_col_ack), 0);
    chk("col_safe_idle", int'(o_col_safe), 0);

    // held request: acks two cycles after grant, gap of one cycle
    i_col_req = 1'b1;
    i_col_x = 7'd79;
    i_col_y = 6'd59;
    ack_m = '0;
    safe_m = '0;
    for (int s = 0; s < 7; s++) begin
      step();
      ack_m[s] = o_col_ack;
      safe_m[s] = o_col_safe;
    end
    chk("col_ack_pattern", int'(ack_m), 7'b0010010);
    chk("col_safe_pattern", int'(safe_m), 7'b0010010);
    i_col_req = 1'b0;
    repeat (3) step();

    // build 2: generator never goes busy -> timeout
    regen();
    wait_start(n);
    chk("gen_start_cycle2", n, 4800);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_map_valid && n < 200);
    chk("timeout_cycles", n, 100);
    chk("timeout_err", int'(o_gen_err), 1);

    // build 3: regen during GEN queues another build
    regen();
    wait_start(n);
    i_gen_rdy = 1'b0;
    i_regen_req = 1'b1;
    wr(10, 10, 1'b1);
    step();
    i_regen_req = 1'b0;
    i_wr_valid = 1'b0;
    i_gen_rdy = 1'b1;
    step();
    chk("pend_ready", int'(o_map_valid), 1);
    chk("err_cleared", int'(o_gen_err), 0);
    step();
    chk("pend_clear_busy", int'(o_busy), 1);
    chk("pend_clear_valid", int'(o_map_valid), 0);

    // build 4: no writes, map must read back all zero
    wait_start(n);
    chk("gen_start_cycle4", n, 4800);
    i_gen_rdy = 1'b0;
    step();
    i_gen_rdy = 1'b1;
    step();
    chk("ready4", int'(o_map_valid), 1);
    for (int i = 0; i < 4800; i++) model[i] = 1'b0;
    readback("readback_clear");

    // reset in the middle of CLEAR
    regen();
    repeat (100) step();
    chk("mid_clear_busy", int'(o_busy), 1);
    arst_n = 1'b0;
    step();
    chk("mid_reset_outputs", outs(), 0);
    arst_n = 1'b1;
    step();
    chk("post_reset_idle", outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
